regfile_arbiter: RTL and testbench

Arbitrates two requesters onto one single-port 256x16 register array: the configuration port (A, register-interface master side) and the serial port (B, two-wire slave side). Port A has fixed priority, and port B has a starvation bound. Each requester sees a simple req/ack transaction. The block drives the memory's enable, write-enable, address and write-data, and returns read data to the requester it served. It sits between the protocol front-ends and the shared register storage, replacing ad-hoc per-front-end access and collision checks.

---
 rtl/regfile_arbiter.sv | 138 +++++++++++++
 tb/tb_regfile_arbiter.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_arbiter.sv
// Arbitrates configuration port A (fixed priority) and serial port B (starvation-bounded)
// onto one single-port register array; each requester sees a req/ack transaction.
`timescale 1ns/1ps
module regfile_arbiter #(
    parameter int AW     = 8,
    parameter int DW     = 16,
    parameter int STARVE = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          a_req,
    input  logic          a_we,
    input  logic [AW-1:0] a_addr,
    input  logic [DW-1:0] a_wdata,
    output logic          a_ack,
    output logic [DW-1:0] a_rdata,
    input  logic          b_req,
    input  logic          b_we,
    input  logic [AW-1:0] b_addr,
    input  logic [DW-1:0] b_wdata,
    output logic          b_ack,
    output logic [DW-1:0] b_rdata,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          busy,
    output logic [1:0]    dbg_state,
    output logic [3:0]    dbg_starve_cnt
);

    // Handshake: a requester holds req and its command stable until it sees a
    // one-cycle ack; a port is not re-granted in its own ack cycle.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [3:0]      starve_q, starve_d;
    logic            id_q, id_d;
    logic            we_q, we_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [DW-1:0]   wdata_q, wdata_d;
    logic            a_ack_q, a_ack_d;
    logic            b_ack_q, b_ack_d;
    logic [DW-1:0]   a_rdata_q, a_rdata_d;
    logic [DW-1:0]   b_rdata_q, b_rdata_d;
    logic            a_elig, b_elig, pick_b;

    assign a_elig = a_req & ~a_ack_q;
    assign b_elig = b_req & ~b_ack_q;

    always_comb begin
        state_d   = state_q;
        starve_d  = starve_q;
        id_d      = id_q;
        we_d      = we_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        a_ack_d   = 1'b0;
        b_ack_d   = 1'b0;
        a_rdata_d = a_rdata_q;
        b_rdata_d = b_rdata_q;
        pick_b    = 1'b0;
        case (state_q)
            IDLE: begin
                if (a_elig || b_elig) begin
                    pick_b  = b_elig && (!a_elig || (starve_q >= 4'(STARVE)));
                    id_d    = pick_b;
                    we_d    = pick_b ? b_we    : a_we;
                    addr_d  = pick_b ? b_addr  : a_addr;
                    wdata_d = pick_b ? b_wdata : a_wdata;
                    state_d = ACCESS;
                    if (pick_b) begin
                        starve_d = 4'd0;
                    end else if (b_req && (starve_q != 4'hf)) begin
                        starve_d = starve_q + 4'd1;
                    end
                end
            end
            ACCESS: state_d = RESP;
            RESP: begin
                state_d = IDLE;
                if (id_q) begin
                    b_ack_d = 1'b1;
                    if (!we_q) b_rdata_d = mem_rdata;
                end else begin
                    a_ack_d = 1'b1;
                    if (!we_q) a_rdata_d = mem_rdata;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            starve_q  <= 4'd0;
            id_q      <= 1'b0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            a_ack_q   <= 1'b0;
            b_ack_q   <= 1'b0;
            a_rdata_q <= '0;
            b_rdata_q <= '0;
        end else begin
            state_q   <= state_d;
            starve_q  <= starve_d;
            id_q      <= id_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            a_ack_q   <= a_ack_d;
            b_ack_q   <= b_ack_d;
            a_rdata_q <= a_rdata_d;
            b_rdata_q <= b_rdata_d;
        end
    end

    // Strobe is gated by reset so a reset landing on ACCESS never writes the array.
    assign mem_en         = (state_q == ACCESS) && !reset;
    assign mem_we         = mem_en && we_q;
    assign mem_addr       = addr_q;
    assign mem_wdata      = wdata_q;
    assign a_ack          = a_ack_q;
    assign b_ack          = b_ack_q;
    assign a_rdata        = a_rdata_q;
    assign b_rdata        = b_rdata_q;
    assign busy           = (state_q != IDLE);
    assign dbg_state      = state_q;
    assign dbg_starve_cnt = starve_q;

endmodule

// File: tb/tb_regfile_arbiter.sv
// Directed bench for regfile_arbiter: requester drivers push expected acks into
// per-port queues; a negedge monitor pops and checks ack cycle and read data.
`timescale 1ns/1ps
module tb_regfile_arbiter;
    localparam int AW = 8;
    localparam int DW = 16;
    localparam int STARVE = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          a_req, a_we, a_ack;
    logic [AW-1:0] a_addr;
    logic [DW-1:0] a_wdata, a_rdata;
    logic          b_req, b_we, b_ack;
    logic [AW-1:0] b_addr;
    logic [DW-1:0] b_wdata, b_rdata;
    logic          mem_en, mem_we, busy;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata;
    logic [1:0]    dbg_state;
    logic [3:0]    dbg_starve_cnt;

    logic [DW-1:0] mem [0:255];
    logic [31:0]   exp_a_q[$];
    logic [31:0]   exp_b_q[$];
    logic [31:0]   e_a, e_b;
    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int en_cnt = 0;
    int a_ack_cnt = 0;
    int b_ack_cnt = 0;
    int c0, en0, ack0;

    regfile_arbiter #(.AW(AW), .DW(DW), .STARVE(STARVE)) dut (
        .clk(clk), .reset(reset),
        .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
        .a_ack(a_ack), .a_rdata(a_rdata),
        .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
        .b_ack(b_ack), .b_rdata(b_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .busy(busy), .dbg_state(dbg_state), .dbg_starve_cnt(dbg_starve_cnt)
    );

    // Clock / reset
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Single-port array model: registered read, data valid the cycle after mem_en
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) mem[mem_addr] <= mem_wdata;
            mem_rdata <= mem[mem_addr];
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor / scoreboard
    always @(negedge clk) begin
        if (!reset) begin
            if (mem_en) en_cnt++;
            if (a_ack) begin
                a_ack_cnt++;
                if (exp_a_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL a_ack_unexpected: got ack expected none (cycle %0d)", cyc);
                end else begin
                    e_a = exp_a_q.pop_front();
                    chk("a_ack_cycle", cyc, 32'(e_a[31:16]));
                    chk("a_rdata", 32'(a_rdata), 32'(e_a[15:0]));
                end
            end
            if (b_ack) begin
                b_ack_cnt++;
                if (exp_b_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL b_ack_unexpected: got ack expected none (cycle %0d)", cyc);
                end else begin
                    e_b = exp_b_q.pop_front();
                    chk("b_ack_cycle", cyc, 32'(e_b[31:16]));
                    chk("b_rdata", 32'(b_rdata), 32'(e_b[15:0]));
                end
            end
        end
    end

    // Driver: issue at a negedge, hold until one cycle past the ack, then release.
    task automatic run(input bit port, input logic we, input logic [AW-1:0] addr,
                       input logic [DW-1:0] wdata, input logic [DW-1:0] exp_rd, input int lat);
        bit got;
        if (!port) begin
            a_we = we; a_addr = addr; a_wdata = wdata; a_req = 1'b1;
            exp_a_q.push_back({16'(cyc + lat), exp_rd});
        end else begin
            b_we = we; b_addr = addr; b_wdata = wdata; b_req = 1'b1;
            exp_b_q.push_back({16'(cyc + lat), exp_rd});
        end
        got = 1'b0;
        for (int n = 0; n < 40 && !got; n++) begin
            @(negedge clk);
            got = port ? b_ack : a_ack;
        end
        if (!got) begin
            checks++; errors++;
            $display("FAIL %s_timeout: got no ack expected ack within 40 cycles", port ? "b" : "a");
        end
        @(negedge clk);
        if (!port) a_req = 1'b0; else b_req = 1'b0;
    endtask

    task automatic chk_reset_values(input string tag);
        chk({tag, "_a_ack"}, 32'(a_ack), 32'd0);
        chk({tag, "_b_ack"}, 32'(b_ack), 32'd0);
        chk({tag, "_a_rdata"}, 32'(a_rdata), 32'd0);
        chk({tag, "_b_rdata"}, 32'(b_rdata), 32'd0);
        chk({tag, "_mem_en"}, 32'(mem_en), 32'd0);
        chk({tag, "_mem_we"}, 32'(mem_we), 32'd0);
        chk({tag, "_mem_addr"}, 32'(mem_addr), 32'd0);
        chk({tag, "_mem_wdata"}, 32'(mem_wdata), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_state"}, 32'(dbg_state), 32'd0);
        chk({tag, "_starve"}, 32'(dbg_starve_cnt), 32'd0);
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: got no end expected finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = '0;
        mem_rdata = '0;
        reset = 1'b1;
        a_req = 0; a_we = 0; a_addr = '0; a_wdata = '0;
        b_req = 0; b_we = 0; b_addr = '0; b_wdata = '0;
        repeat (3) @(negedge clk);
        chk_reset_values("reset");
        reset = 1'b0;
        @(negedge clk);

        // A write 0xBEEF to 0x12, then read it back
        fork
            run(0, 1'b1, 8'h12, 16'hBEEF, 16'h0000, 3);
            begin
                @(negedge clk);
                chk("access_busy", 32'(busy), 32'd1);
                chk("access_mem_en", 32'(mem_en), 32'd1);
                chk("access_mem_we", 32'(mem_we), 32'd1);
                chk("access_mem_addr", 32'(mem_addr), 32'h12);
                chk("access_mem_wdata", 32'(mem_wdata), 32'hBEEF);
            end
        join
        run(0, 1'b0, 8'h12, 16'h0000, 16'hBEEF, 3);

        // Simultaneous writes to 0x40: A first, B three cycles after A's ack
        fork
            run(0, 1'b1, 8'h40, 16'h1111, 16'hBEEF, 3);
            run(1, 1'b1, 8'h40, 16'h2222, 16'h0000, 6);
        join
        run(0, 1'b0, 8'h40, 16'h0000, 16'h2222, 3);
        chk("starve_after_b_grant", 32'(dbg_starve_cnt), 32'd0);

        // Starvation: A back-to-back; B requests except in A's ack cycles
        c0 = cyc;
        b_we = 1'b0; b_addr = 8'h40; b_wdata = '0;
        exp_b_q.push_back({16'(c0 + 19), 16'h2222});
        fork
            begin
                for (int k = 0; k < 4; k++) run(0, 1'b0, 8'h12, 16'h0000, 16'hBEEF, 3);
                run(0, 1'b0, 8'h12, 16'h0000, 16'hBEEF, 6);
            end
            begin
                bit done;
                done = 1'b0;
                b_req = 1'b1;
                for (int i = 1; i < 60 && !done; i++) begin
                    @(negedge clk);
                    if (i == 16) chk("starve_cnt_full", 32'(dbg_starve_cnt), 32'd4);
                    b_req = !a_ack;
                    if (b_ack) begin
                        b_req = 1'b0;
                        done = 1'b1;
                        chk("starve_cnt_cleared", 32'(dbg_starve_cnt), 32'd0);
                    end
                end
                if (!done) begin
                    checks++; errors++;
                    $display("FAIL starve_b_timeout: got no b_ack expected b_ack");
                end
            end
        join

        // Ack mask: request held through the ack cycle gets exactly one access
        en0 = en_cnt;
        ack0 = a_ack_cnt;
        run(0, 1'b1, 8'h33, 16'h5A5A, 16'hBEEF, 3);
        repeat (4) @(negedge clk);
        chk("mask_mem_en_pulses", 32'(en_cnt - en0), 32'd1);
        chk("mask_a_acks", 32'(a_ack_cnt - ack0), 32'd1);

        // Reset during ACCESS of a B write drops it
        run(1, 1'b1, 8'h05, 16'h0001, 16'h2222, 3);
        b_we = 1'b1; b_addr = 8'h05; b_wdata = 16'hAAAA; b_req = 1'b1;
        @(negedge clk);
        chk("rst_access_mem_en", 32'(mem_en), 32'd1);
        reset = 1'b1;
        b_req = 1'b0;
        #1;
        chk("rst_gated_mem_en", 32'(mem_en), 32'd0);
        chk("rst_gated_mem_we", 32'(mem_we), 32'd0);
        @(negedge clk);
        chk_reset_values("midrst");
        reset = 1'b0;
        ack0 = b_ack_cnt;
        repeat (5) @(negedge clk);
        chk("rst_no_b_ack", 32'(b_ack_cnt - ack0), 32'd0);
        run(1, 1'b0, 8'h05, 16'h0000, 16'h0001, 3);

        repeat (3) @(negedge clk);
        chk("exp_a_q_drained", 32'(exp_a_q.size()), 32'd0);
        chk("exp_b_q_drained", 32'(exp_b_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
